entrada_jogada: RTL and testbench
=================================

// Module: entrada_jogada
// PURPOSE
//  Player-side move entry for the chess trainer: debounces a 4-bit keypad, collects a column key then a row key,
//  and presents the square as jogadaColuna/jogadaFileira with a one-cycle temJogada strobe.
//  Producer of the move handshake consumed by the game datapath/controller; sits between keypad pins and game top.
// PARAMETERS
//  DEBOUNCE_CICLOS  4     consecutive stable cycles required on tecla_pressionada for press and for release
//  TIMEOUT_CICLOS   5000  cycles allowed in FILEIRA before abandoning entry (only with ENTRADA_TIMEOUT_EN)
// PORTS
//  clock              in   1  system clock, all logic on rising edge
//  reset              in   1  synchronous, active-high
//  tecla              in   4  keypad code, valid while tecla_pressionada is high
//  tecla_pressionada  in   1  raw, bouncy key-down level
//  habilitar          in   1  game accepting moves; low discards any partial entry
//  jogadaColuna       out  4  registered column 0..7 (displayed A..H)
//  jogadaFileira      out  4  registered row 0..7
//  temJogada          out  1  one-cycle strobe, square outputs valid that cycle
//  aguardandoFileira  out  1  high while in FILEIRA (column accepted)
//  erro_tecla         out  1  one-cycle pulse on accepted invalid key
//  db_timeout         out  1  one-cycle pulse on entry timeout
//  db_estado          out  4  current state encoding
// BEHAVIOUR
//  Reset: state INICIAL, all outputs 0, debounce counters 0, press latch clear.
//  Debounce: press accepted when tecla_pressionada high for DEBOUNCE_CICLOS consecutive cycles; produces one
//   internal pulse `aceita` with tecla sampled that cycle; next press requires low for DEBOUNCE_CICLOS first.
//   Holding a key never repeats. Any glitch restarts the count.
//  States (db_estado): INICIAL=0, COLUNA=1, FILEIRA=2, EMITE=3.
//   INICIAL: habilitar=1 -> COLUNA.
//   COLUNA: aceita & tecla<=7 -> latch column, FILEIRA. aceita & tecla=F -> stay. aceita & tecla 8..E -> erro_tecla, stay.
//   FILEIRA: aceita & tecla<=7 -> latch row, EMITE. tecla=F -> COLUNA (cancel). tecla 8..E -> erro_tecla, stay.
//   EMITE: temJogada=1 for exactly this cycle; jogadaColuna/Fileira updated entering EMITE and held until next EMITE;
//    -> COLUNA unconditionally (an aceita in this cycle is processed as a column key in COLUNA next cycle? no: dropped).
//  Latency: aceita on row key at cycle N -> temJogada high at N+1.
//  habilitar=0 in any state -> INICIAL next cycle; overrides simultaneous aceita (no emission, no erro_tecla).
//  Reset mid-entry: partial column discarded, held square outputs return to 0.
//  erro_tecla and db_timeout never assert in the same cycle as temJogada.
// CONFIGURATION
//  ENTRADA_TIMEOUT_EN defined: counter runs in FILEIRA, cleared on state entry and on every aceita; reaching
//   TIMEOUT_CICLOS -> COLUNA, db_timeout pulse one cycle; aceita in the expiring cycle wins over timeout.
//  Undefined: FILEIRA waits indefinitely; no timeout counter; db_timeout tied 0.
// STRUCTURE
//  Package entrada_jogada_pkg: state encodings (INICIAL..EMITE), TECLA_CANCELA=4'hF, COORD_MAX=4'd7.
//  Sub-module debounce_tecla (clock, reset, nivel, pulso; parameter DEBOUNCE_CICLOS); counters sized $clog2.
//  Top holds FSM, column/row/output registers and optional timeout counter.
// TESTING (DEBOUNCE_CICLOS=4, TIMEOUT_CICLOS=20)
//  habilitar=1; press 3 (held 6 cyc, released 6), press 5 -> one temJogada, jogadaColuna=3, jogadaFileira=5, held.
//  Bouncy press 1-0-1-1-1-0 then stable 4 cyc -> exactly one aceita, counted from last stable run.
//  Column 2, then key 9 -> erro_tecla pulse, stays FILEIRA; then F -> COLUNA; then 4,6 -> temJogada col 4 row 6.
//  Column 7 then habilitar=0 same cycle as row key 1 accepted -> no temJogada, db_estado=0 next cycle.
//  Reset asserted in FILEIRA -> all outputs 0 next cycle; key held across reset not accepted until released.
//  ENTRADA_TIMEOUT_EN: column 1, idle 20 cyc -> db_timeout pulse, db_estado=1; without macro, no change after 100 cyc.

Source files
------------

// File: rtl/entrada_jogada_pkg.sv
// Shared encodings for the chess-trainer move entry: FSM states and keypad codes.
package entrada_jogada_pkg;

  typedef enum logic [3:0] {
    INICIAL = 4'd0,
    COLUNA  = 4'd1,
    FILEIRA = 4'd2,
    EMITE   = 4'd3
  } estado_t;

  localparam logic [3:0] TECLA_CANCELA = 4'hF;
  localparam logic [3:0] COORD_MAX     = 4'd7;

  function automatic logic coord_valida(input logic [3:0] t);
    return t <= COORD_MAX;
  endfunction

endpackage

// File: rtl/entrada_jogada_debounce.sv
// Keypad debouncer: one pulse per debounced press; a release must be seen (also debounced)
// before the next press is accepted, including right after reset.
module debounce_tecla #(
  parameter int DEBOUNCE_CICLOS = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic nivel,
  output logic pulso
);

  localparam int CNT_W = (DEBOUNCE_CICLOS > 1) ? $clog2(DEBOUNCE_CICLOS) : 1;
  localparam logic [CNT_W-1:0] CNT_FIM = CNT_W'(DEBOUNCE_CICLOS - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pressionado_q, pressionado_d;
  logic             armado_q, armado_d;
  logic             alvo;

  // alvo is the level we are waiting to see stable: high only once armed and not already pressed
  always_comb begin
    alvo          = armado_q & ~pressionado_q;
    cnt_d         = '0;
    pressionado_d = pressionado_q;
    armado_d      = armado_q;
    pulso         = 1'b0;
    if (nivel == alvo) begin
      if (cnt_q == CNT_FIM) begin
        if (alvo) begin
          pressionado_d = 1'b1;
          pulso         = 1'b1;
        end else begin
          pressionado_d = 1'b0;
          armado_d      = 1'b1;
        end
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q         <= '0;
      pressionado_q <= 1'b0;
      armado_q      <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      pressionado_q <= pressionado_d;
      armado_q      <= armado_d;
    end
  end

endmodule

// File: rtl/entrada_jogada.sv
// Move entry: debounced column key then row key, emitted as a square with a one-cycle strobe.
// Optional FILEIRA timeout enabled by defining ENTRADA_TIMEOUT_EN.
module entrada_jogada
  import entrada_jogada_pkg::*;
#(
  parameter int DEBOUNCE_CICLOS = 4,
  parameter int TIMEOUT_CICLOS  = 5000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] tecla,
  input  logic       tecla_pressionada,
  input  logic       habilitar,
  output logic [3:0] jogadaColuna,
  output logic [3:0] jogadaFileira,
  output logic       temJogada,
  output logic       aguardandoFileira,
  output logic       erro_tecla,
  output logic       db_timeout,
  output logic [3:0] db_estado
);

  estado_t    estado_q, estado_d;
  logic [3:0] coluna_q, coluna_d;
  logic [3:0] jog_col_q, jog_col_d;
  logic [3:0] jog_fil_q, jog_fil_d;
  logic       erro_q, erro_d;
  logic       timeout_q, timeout_d;
  logic       aceita;
  logic       expira;

  debounce_tecla #(.DEBOUNCE_CICLOS(DEBOUNCE_CICLOS)) u_debounce (
    .clock (clock),
    .reset (reset),
    .nivel (tecla_pressionada),
    .pulso (aceita)
  );

`ifdef ENTRADA_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;
  logic [TMO_W-1:0] tmo_q, tmo_d;

  always_comb begin
    expira = (estado_q == FILEIRA) && (tmo_q == TMO_W'(TIMEOUT_CICLOS - 1));
    tmo_d  = tmo_q + TMO_W'(1);
    if (estado_q != FILEIRA || aceita || expira) tmo_d = '0;
  end

  always_ff @(posedge clock) begin
    if (reset) tmo_q <= '0;
    else       tmo_q <= tmo_d;
  end
`else
  logic [31:0] unused_timeout_ciclos;
  assign unused_timeout_ciclos = TIMEOUT_CICLOS;
  assign expira = 1'b0;
`endif

  // habilitar low wins over everything, including a key accepted in the same cycle
  always_comb begin
    estado_d  = estado_q;
    coluna_d  = coluna_q;
    jog_col_d = jog_col_q;
    jog_fil_d = jog_fil_q;
    erro_d    = 1'b0;
    timeout_d = 1'b0;
    if (!habilitar) begin
      estado_d = INICIAL;
    end else begin
      unique case (estado_q)
        INICIAL: estado_d = COLUNA;
        COLUNA: begin
          if (aceita) begin
            if (coord_valida(tecla)) begin
              coluna_d = tecla;
              estado_d = FILEIRA;
            end else if (tecla != TECLA_CANCELA) begin
              erro_d = 1'b1;
            end
          end
        end
        FILEIRA: begin
          if (aceita) begin
            if (coord_valida(tecla)) begin
              jog_col_d = coluna_q;
              jog_fil_d = tecla;
              estado_d  = EMITE;
            end else if (tecla == TECLA_CANCELA) begin
              estado_d = COLUNA;
            end else begin
              erro_d = 1'b1;
            end
          end else if (expira) begin
            estado_d  = COLUNA;
            timeout_d = 1'b1;
          end
        end
        EMITE:   estado_d = COLUNA;
        default: estado_d = INICIAL;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q  <= INICIAL;
      coluna_q  <= '0;
      jog_col_q <= '0;
      jog_fil_q <= '0;
      erro_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      coluna_q  <= coluna_d;
      jog_col_q <= jog_col_d;
      jog_fil_q <= jog_fil_d;
      erro_q    <= erro_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    temJogada         = (estado_q == EMITE);
    aguardandoFileira = (estado_q == FILEIRA);
    db_estado         = estado_q;
    jogadaColuna      = jog_col_q;
    jogadaFileira     = jog_fil_q;
    erro_tecla        = erro_q;
    db_timeout        = timeout_q;
  end

endmodule

// File: tb/tb_entrada_jogada.sv
// Directed bench for entrada_jogada: move entry, bounce, invalid/cancel keys, habilitar, reset, timeout.
module tb_entrada_jogada;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] tecla;
  logic       tecla_pressionada;
  logic       habilitar;
  logic [3:0] jogadaColuna, jogadaFileira, db_estado;
  logic       temJogada, aguardandoFileira, erro_tecla, db_timeout;

  int n_checks = 0;
  int n_errors = 0;
  int n_jog = 0, n_erro = 0, n_tmo = 0, n_conflito = 0;
  logic [3:0] ult_col = '0, ult_fil = '0;

  entrada_jogada #(.DEBOUNCE_CICLOS(4), .TIMEOUT_CICLOS(20)) dut (
    .clock             (clock),
    .reset             (reset),
    .tecla             (tecla),
    .tecla_pressionada (tecla_pressionada),
    .habilitar         (habilitar),
    .jogadaColuna      (jogadaColuna),
    .jogadaFileira     (jogadaFileira),
    .temJogada         (temJogada),
    .aguardandoFileira (aguardandoFileira),
    .erro_tecla        (erro_tecla),
    .db_timeout        (db_timeout),
    .db_estado         (db_estado)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (temJogada) begin
      n_jog++;
      ult_col = jogadaColuna;
      ult_fil = jogadaFileira;
    end
    if (erro_tecla) n_erro++;
    if (db_timeout) n_tmo++;
    if (temJogada && (erro_tecla || db_timeout)) n_conflito++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic press(input logic [3:0] k, input int hold, input int rel);
    tecla = k;
    tecla_pressionada = 1'b1;
    repeat (hold) tick();
    tecla_pressionada = 1'b0;
    repeat (rel) tick();
  endtask

  initial begin
    logic bounce [10];
    bounce = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    reset = 1'b1; habilitar = 1'b0; tecla = '0; tecla_pressionada = 1'b0;
    repeat (3) tick();
    check("rst_estado", db_estado, 0);
    check("rst_tem", temJogada, 0);
    check("rst_col", jogadaColuna, 0);
    check("rst_fil", jogadaFileira, 0);
    check("rst_erro", erro_tecla, 0);
    check("rst_tmo", db_timeout, 0);

    // enable, arm debouncer with idle low cycles
    reset = 1'b0; habilitar = 1'b1;
    tick();
    check("ini_coluna", db_estado, 1);
    repeat (5) tick();

    // basic move: column 3, row 5; strobe on the 4th stable high cycle
    press(4'd3, 6, 6);
    check("col3_estado", db_estado, 2);
    check("col3_aguard", aguardandoFileira, 1);
    tecla = 4'd5; tecla_pressionada = 1'b1;
    repeat (4) tick();
    check("lat_tem", temJogada, 1);
    check("lat_col", jogadaColuna, 3);
    check("lat_fil", jogadaFileira, 5);
    tick();
    check("lat_tem_off", temJogada, 0);
    tick();
    tecla_pressionada = 1'b0;
    repeat (6) tick();
    check("mv1_njog", n_jog, 1);
    check("mv1_hold_col", jogadaColuna, 3);
    check("mv1_hold_fil", jogadaFileira, 5);
    check("mv1_estado", db_estado, 1);

    // bouncy press of column 1: accepted only after 4 stable highs
    tecla = 4'd1;
    for (int i = 0; i < 9; i++) begin
      tecla_pressionada = bounce[i];
      tick();
    end
    check("bounce_wait", db_estado, 1);
    tecla_pressionada = bounce[9];
    tick();
    check("bounce_acc", db_estado, 2);
    tecla_pressionada = 1'b0;
    repeat (6) tick();
    press(4'hF, 6, 6);
    check("cancel_estado", db_estado, 1);
    check("cancel_njog", n_jog, 1);

    // F in COLUNA is silent, 8 in COLUNA is an error
    press(4'hF, 6, 6);
    check("colF_estado", db_estado, 1);
    check("colF_erro", n_erro, 0);
    press(4'd8, 6, 6);
    check("col8_erro", n_erro, 1);
    check("col8_estado", db_estado, 1);

    // column 2, invalid 9, cancel, then 4,6
    press(4'd2, 6, 6);
    press(4'd9, 6, 6);
    check("fil9_erro", n_erro, 2);
    check("fil9_estado", db_estado, 2);
    press(4'hF, 6, 6);
    check("filF_estado", db_estado, 1);
    check("filF_erro", n_erro, 2);
    press(4'd4, 6, 6);
    press(4'd6, 6, 6);
    check("mv2_njog", n_jog, 2);
    check("mv2_col", ult_col, 4);
    check("mv2_fil", ult_fil, 6);

    // column 7 (upper bound), habilitar drops in the cycle row 1 is accepted
    press(4'd7, 6, 6);
    check("col7_estado", db_estado, 2);
    tecla = 4'd1; tecla_pressionada = 1'b1;
    repeat (3) tick();
    habilitar = 1'b0;
    tick();
    check("hab_estado", db_estado, 0);
    tick();
    tecla_pressionada = 1'b0;
    repeat (6) tick();
    check("hab_njog", n_jog, 2);
    check("hab_erro", n_erro, 2);
    check("hab_col_held", jogadaColuna, 4);
    habilitar = 1'b1;
    tick();
    check("hab_reen", db_estado, 1);

    // reset in FILEIRA with a key held across it
    press(4'd2, 6, 6);
    check("pre_rst_estado", db_estado, 2);
    tecla = 4'd3; tecla_pressionada = 1'b1; reset = 1'b1;
    tick();
    check("mrst_estado", db_estado, 0);
    check("mrst_col", jogadaColuna, 0);
    check("mrst_fil", jogadaFileira, 0);
    check("mrst_aguard", aguardandoFileira, 0);
    reset = 1'b0;
    repeat (8) tick();
    check("held_not_acc", db_estado, 1);
    tecla_pressionada = 1'b0;
    repeat (6) tick();
    press(4'd5, 6, 6);
    check("post_rst_acc", db_estado, 2);

    // idle in FILEIRA
`ifdef ENTRADA_TIMEOUT_EN
    repeat (20) tick();
    check("tmo_pulse", n_tmo, 1);
    check("tmo_estado", db_estado, 1);
`else
    repeat (100) tick();
    check("notmo_pulse", n_tmo, 0);
    check("notmo_estado", db_estado, 2);
`endif
    check("conflito", n_conflito, 0);
    check("final_njog", n_jog, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
